// File: rtl/dbus_pkg.sv
// Shared encodings for the processor data bus: transfer sizes, responder
// FSM states and the default memory-mapped I/O addresses.
package dbus_pkg;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACK
  } state_t;

  localparam logic [31:0] DEF_STDOUT_ADDR = 32'hf000_0000;
  localparam logic [31:0] DEF_EXIT_ADDR   = 32'hff00_0000;

  // Encodings 10 and 11 both mean a byte transfer.
  function automatic logic is_byte_size(input logic [1:0] sz);
    return sz[1];
  endfunction

endpackage

// File: rtl/dmem_byte_ram.sv
// Word-indexed RAM built from four byte lanes; lane i holds word bits
// [8i+7:8i]. Synchronous per-lane write, combinational read.
module dmem_byte_ram #(
  parameter int unsigned WORDS = 16384,
  parameter int unsigned IDX_W = $clog2(WORDS)
) (
  input  logic             clk,
  input  logic [3:0]       we,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  for (genvar i = 0; i < 4; i++) begin : g_lane
    logic [7:0] lane [WORDS];

    always_ff @(posedge clk) begin
      if (we[i]) lane[idx] <= wdata[8*i +: 8];
    end

    assign rdata[8*i +: 8] = lane[idx];
  end

endmodule

// File: rtl/dmem_bus_responder.sv
// Cycle-accurate big-endian data-memory slave with configurable load/store
// latency, STDOUT/EXIT decode and error flagging for bad accesses.
module dmem_bus_responder
  import dbus_pkg::*;
#(
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       MEM_BYTES   = 65536,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(32'h8000_0000),
  parameter int unsigned       LOAD_LAT    = 1,
  parameter int unsigned       STORE_LAT   = 1,
  parameter logic [ADDR_W-1:0] STDOUT_ADDR = ADDR_W'(DEF_STDOUT_ADDR),
  parameter logic [ADDR_W-1:0] EXIT_ADDR   = ADDR_W'(DEF_EXIT_ADDR)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MREQ,
  input  logic              WRITE,
  input  logic [1:0]        SIZE,
  input  logic [ADDR_W-1:0] DAD,
  inout  wire  [31:0]       DDT,
  output logic              ACKD_n,
  output logic              stdout_valid,
  output logic [7:0]        stdout_char,
  output logic              exit_req,
  output logic              err
);

  localparam int unsigned WORDS = MEM_BYTES / 4;
  localparam int unsigned IDX_W = $clog2(WORDS);

  if (LOAD_LAT < 1 || LOAD_LAT > 15) begin : g_bad_load_lat
    $error("dmem_bus_responder: LOAD_LAT must be in 1..15");
  end
  if (STORE_LAT < 1 || STORE_LAT > 15) begin : g_bad_store_lat
    $error("dmem_bus_responder: STORE_LAT must be in 1..15");
  end
  if (MEM_BYTES < 8 || (MEM_BYTES & (MEM_BYTES - 1)) != 0) begin : g_bad_mem
    $error("dmem_bus_responder: MEM_BYTES must be a power of 2, at least 8");
  end

  state_t            state, state_n;
  logic [3:0]        cnt, cnt_n;
  logic              commit;
  logic [ADDR_W-1:0] lat_addr;
  logic [1:0]        lat_size;
  logic              lat_write;
  logic [31:0]       lat_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    commit  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (MREQ) begin
          state_n = ST_WAIT;
          cnt_n   = WRITE ? 4'(STORE_LAT - 1) : 4'(LOAD_LAT - 1);
        end
      end
      ST_WAIT: begin
        if (!MREQ) begin
          state_n = ST_IDLE;
        end else if (cnt == 4'd0) begin
          state_n = ST_ACK;
          commit  = 1'b1;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      ST_ACK:  state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // Request fields are captured once at acceptance; DDT carries store data then.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lat_addr  <= '0;
      lat_size  <= SZ_WORD;
      lat_write <= 1'b0;
      lat_data  <= 32'd0;
    end else if (state == ST_IDLE && MREQ) begin
      lat_addr  <= DAD;
      lat_size  <= SIZE;
      lat_write <= WRITE;
      lat_data  <= DDT;
    end
  end

  logic [ADDR_W-1:0] offset;
  logic              in_range, is_stdout, is_exit, misaligned;
  logic [1:0]        byte_sel;
  logic [3:0]        we, ram_we;
  logic [31:0]       wdata, rd, load_val;
  logic              acc_err, char_hit, exit_hit;

  assign offset     = lat_addr - BASE_ADDR;
  assign in_range   = {1'b0, offset} < (ADDR_W + 1)'(MEM_BYTES);
  assign is_stdout  = (lat_addr == STDOUT_ADDR);
  assign is_exit    = (lat_addr == EXIT_ADDR);
  assign byte_sel   = lat_addr[1:0];
  assign misaligned = ((lat_size == SZ_HALF) && byte_sel[0]) ||
                      ((lat_size == SZ_WORD) && (byte_sel != 2'b00));

  // Byte offset k within a word lives in bits [31-8k -: 8] (big-endian).
  always_comb begin
    we       = 4'b0000;
    wdata    = lat_data;
    load_val = 32'd0;
    acc_err  = 1'b0;
    char_hit = 1'b0;
    exit_hit = 1'b0;
    if (lat_write) begin
      if (is_exit) begin
        exit_hit = 1'b1;
      end else if (is_stdout) begin
        if (is_byte_size(lat_size)) char_hit = 1'b1;
        else                        acc_err  = 1'b1;
      end else if (misaligned || !in_range) begin
        acc_err = 1'b1;
      end else if (lat_size == SZ_WORD) begin
        we = 4'b1111;
      end else if (lat_size == SZ_HALF) begin
        we    = byte_sel[1] ? 4'b0011 : 4'b1100;
        wdata = {2{lat_data[15:0]}};
      end else begin
        we    = 4'b1000 >> byte_sel;
        wdata = {4{lat_data[7:0]}};
      end
    end else if (!is_stdout && !is_exit) begin
      if (misaligned || !in_range) begin
        acc_err = 1'b1;
      end else if (lat_size == SZ_WORD) begin
        load_val = rd;
      end else if (lat_size == SZ_HALF) begin
        load_val = {16'd0, byte_sel[1] ? rd[15:0] : rd[31:16]};
      end else begin
        case (byte_sel)
          2'd0:    load_val = {24'd0, rd[31:24]};
          2'd1:    load_val = {24'd0, rd[23:16]};
          2'd2:    load_val = {24'd0, rd[15:8]};
          default: load_val = {24'd0, rd[7:0]};
        endcase
      end
    end
  end

  assign ram_we = commit ? we : 4'b0000;

  dmem_byte_ram #(
    .WORDS (WORDS),
    .IDX_W (IDX_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .idx   (offset[IDX_W+1:2]),
    .wdata (wdata),
    .rdata (rd)
  );

  logic        drive_en;
  logic [31:0] rdata_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ACKD_n       <= 1'b1;
      drive_en     <= 1'b0;
      rdata_q      <= 32'd0;
      err          <= 1'b0;
      stdout_valid <= 1'b0;
      stdout_char  <= 8'd0;
      exit_req     <= 1'b0;
    end else begin
      ACKD_n       <= !commit;
      drive_en     <= commit && !lat_write;
      err          <= commit && acc_err;
      stdout_valid <= commit && char_hit;
      if (commit)             rdata_q     <= load_val;
      if (commit && char_hit) stdout_char <= lat_data[7:0];
      if (commit && exit_hit) exit_req    <= 1'b1;
    end
  end

  assign DDT = drive_en ? rdata_q : 32'bz;

endmodule

// File: tb/tb_dmem_bus_responder.sv
// Scoreboard bench for dmem_bus_responder: the driver queues expected
// responses, the monitor checks each ACK cycle against the queue head.
module tb_dmem_bus_responder;

  localparam int LOAD_LAT  = 3;
  localparam int STORE_LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mreq = 1'b0;
  logic        write = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [31:0] dad = 32'd0;
  logic        tb_drv = 1'b0;
  logic [31:0] tb_ddt = 32'd0;
  wire  [31:0] ddt;
  logic        ackd_n, stdout_valid, exit_req, err;
  logic [7:0]  stdout_char;

  assign ddt = tb_drv ? tb_ddt : 32'bz;

  dmem_bus_responder #(
    .ADDR_W      (32),
    .MEM_BYTES   (65536),
    .BASE_ADDR   (32'h8000_0000),
    .LOAD_LAT    (LOAD_LAT),
    .STORE_LAT   (STORE_LAT),
    .STDOUT_ADDR (32'hf000_0000),
    .EXIT_ADDR   (32'hff00_0000)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .MREQ         (mreq),
    .WRITE        (write),
    .SIZE         (size),
    .DAD          (dad),
    .DDT          (ddt),
    .ACKD_n       (ackd_n),
    .stdout_valid (stdout_valid),
    .stdout_char  (stdout_char),
    .exit_req     (exit_req),
    .err          (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        is_load;
    logic [31:0] data;
    logic        err;
    logic        sv;
    logic [7:0]  ch;
    int          ack_cyc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every ACK cycle must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst && ackd_n === 1'b0) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("[TB] FAIL spurious_ack: ACK at cycle %0d with nothing outstanding", cyc);
      end else begin
        e = sb.pop_front();
        check_output("ack_cycle", 32'(cyc), 32'(e.ack_cyc));
        check_output("err", {31'd0, err}, {31'd0, e.err});
        check_output("stdout_valid", {31'd0, stdout_valid}, {31'd0, e.sv});
        if (e.is_load) check_output("load_data", ddt, e.data);
        if (e.sv)      check_output("stdout_char", {24'd0, stdout_char}, {24'd0, e.ch});
      end
    end
  end

  task automatic apply_stimulus(input logic wr, input logic [1:0] sz, input logic [31:0] addr,
                                input logic [31:0] data, input logic [31:0] exp_data,
                                input logic exp_err, input logic exp_sv, input logic [7:0] exp_ch);
    exp_t e;
    bit   got;
    @(negedge clk);
    mreq   = 1'b1;
    write  = wr;
    size   = sz;
    dad    = addr;
    tb_ddt = data;
    tb_drv = wr;
    e.is_load = !wr;
    e.data    = exp_data;
    e.err     = exp_err;
    e.sv      = exp_sv;
    e.ch      = exp_ch;
    e.ack_cyc = cyc + 1 + (wr ? STORE_LAT : LOAD_LAT);
    sb.push_back(e);
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (ackd_n === 1'b0) got = 1'b1;
    end
    mreq   = 1'b0;
    write  = 1'b0;
    tb_drv = 1'b0;
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("[TB] FAIL ack_timeout: no ACK for addr %h, expected one within 40 cycles", addr);
      void'(sb.pop_back());
    end
  endtask

  task automatic abort_store(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    mreq   = 1'b1;
    write  = 1'b1;
    size   = 2'b00;
    dad    = addr;
    tb_ddt = data;
    tb_drv = 1'b1;
    @(negedge clk);
    mreq   = 1'b0;
    write  = 1'b0;
    tb_drv = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] start");
    repeat (3) @(negedge clk);
    check_output("reset_ackd_n", {31'd0, ackd_n}, 32'd1);
    check_output("reset_exit_req", {31'd0, exit_req}, 32'd0);
    check_output("reset_err", {31'd0, err}, 32'd0);
    check_output("reset_stdout_valid", {31'd0, stdout_valid}, 32'd0);
    check_output("reset_stdout_char", {24'd0, stdout_char}, 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    apply_stimulus(1'b1, 2'b00, 32'hff00_0000, 32'h0000_0001, 32'd0, 1'b0, 1'b0, 8'h00);
    repeat (3) @(negedge clk);
    check_output("exit_req_set", {31'd0, exit_req}, 32'd1);
    repeat (4) @(negedge clk);
    check_output("exit_req_sticky", {31'd0, exit_req}, 32'd1);

    // Reset asserted while a load sits in WAIT.
    @(negedge clk);
    mreq = 1'b1; write = 1'b0; size = 2'b00; dad = 32'h8000_0000;
    @(negedge clk);
    @(negedge clk);
    rst  = 1'b0;
    mreq = 1'b0;
    #1;
    check_output("midwait_reset_ackd_n", {31'd0, ackd_n}, 32'd1);
    check_output("midwait_reset_exit_req", {31'd0, exit_req}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);

    apply_stimulus(1'b1, 2'b00, 32'h8000_0000, 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b0, 8'h00);
    apply_stimulus(1'b1, 2'b00, 32'h8000_0004, 32'hAABB_CCDD, 32'd0, 1'b0, 1'b0, 8'h00);
    apply_stimulus(1'b0, 2'b00, 32'h8000_0000, 32'd0, 32'hDEAD_BEEF, 1'b0, 1'b0, 8'h00);
    apply_stimulus(1'b0, 2'b01, 32'h8000_0002, 32'd0, 32'h0000_BEEF, 1'b0, 1'b0, 8'h00);
    apply_stimulus(1'b0, 2'b10, 32'h8000_0001, 32'd0, 32'h0000_00AD, 1'b0, 1'b0, 8'h00);

    apply_stimulus(1'b1, 2'b01, 32'h8000_0006, 32'h1234_5678, 32'd0, 1'b0, 1'b0, 8'h00);
    apply_stimulus(1'b0, 2'b00, 32'h8000_0004, 32'd0, 32'hAABB_5678, 1'b0, 1'b0, 8'h00);

    apply_stimulus(1'b1, 2'b10, 32'hf000_0000, 32'h1122_3348, 32'd0, 1'b0, 1'b1, 8'h48);
    apply_stimulus(1'b0, 2'b00, 32'h8000_0000, 32'd0, 32'hDEAD_BEEF, 1'b0, 1'b0, 8'h00);
    apply_stimulus(1'b1, 2'b01, 32'hf000_0000, 32'h0000_4142, 32'd0, 1'b1, 1'b0, 8'h00);
    apply_stimulus(1'b0, 2'b00, 32'hf000_0000, 32'd0, 32'd0, 1'b0, 1'b0, 8'h00);

    apply_stimulus(1'b0, 2'b00, 32'h8000_0002, 32'd0, 32'd0, 1'b1, 1'b0, 8'h00);
    apply_stimulus(1'b0, 2'b00, 32'h7fff_fffc, 32'd0, 32'd0, 1'b1, 1'b0, 8'h00);
    apply_stimulus(1'b0, 2'b11, 32'h8001_0000, 32'd0, 32'd0, 1'b1, 1'b0, 8'h00);
    apply_stimulus(1'b1, 2'b01, 32'h8000_0005, 32'h0000_9999, 32'd0, 1'b1, 1'b0, 8'h00);
    apply_stimulus(1'b0, 2'b00, 32'h8000_0004, 32'd0, 32'hAABB_5678, 1'b0, 1'b0, 8'h00);

    apply_stimulus(1'b1, 2'b11, 32'h8000_0004, 32'h0000_005A, 32'd0, 1'b0, 1'b0, 8'h00);
    apply_stimulus(1'b0, 2'b00, 32'h8000_0004, 32'd0, 32'h5ABB_5678, 1'b0, 1'b0, 8'h00);

    abort_store(32'h8000_0000, 32'h0000_0000);
    apply_stimulus(1'b0, 2'b00, 32'h8000_0000, 32'd0, 32'hDEAD_BEEF, 1'b0, 1'b0, 8'h00);

    repeat (4) @(negedge clk);
    check_output("exit_req_after_reset", {31'd0, exit_req}, 32'd0);
    check_output("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_bus_responder.md
Name: dmem_bus_responder

Overview:
Synthesizable, parametrised data-memory slave for the processor's data bus (DAD/DDT/MREQ/WRITE/SIZE/ACKD_n). It holds big-endian byte-addressed memory and models configurable, independent load and store latency. It decodes the STDOUT and EXIT memory-mapped addresses and flags misaligned or out-of-range accesses. It sits beside top in the simulation/FPGA harness and replaces behavioural memory emulation with a cycle-accurate responder.

Parameters:
ADDR_W, 32, data address width
MEM_BYTES, 65536, memory size in bytes (power of 2, multiple of 4)
BASE_ADDR, 32'h8000_0000, first byte address of memory
LOAD_LAT, 1, cycles from request acceptance to load ACK (1..15)
STORE_LAT, 1, cycles from request acceptance to store ACK (1..15)
STDOUT_ADDR, 32'hf000_0000, byte-store character output address
EXIT_ADDR, 32'hff00_0000, any store here requests simulation exit

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset; asynchronous, active-low
MREQ  in  1  data request valid
WRITE  in  1  1 = store, 0 = load
SIZE  in  2  00 word, 01 halfword, 10/11 byte
DAD  in  ADDR_W  byte address
DDT  inout  32  data bus; driven by block only during load ACK cycle
ACKD_n  out  1  active-low acknowledge, one-cycle pulse
stdout_valid  out  1  one-cycle pulse: byte stored to STDOUT_ADDR
stdout_char  out  8  character, valid with stdout_valid
exit_req  out  1  sticky: store to EXIT_ADDR seen
err  out  1  one-cycle pulse with ACK for misaligned/out-of-range access

Behaviour:
- Reset (rst=0, async): ACKD_n=1, DDT=Z, stdout_valid=0, stdout_char=0, exit_req=0, err=0, FSM=IDLE, counter=0. Memory contents not reset (preload via $readmemh in sim only).
- FSM states: IDLE, WAIT, ACK.
- IDLE: at an edge with MREQ=1, latch DAD, SIZE, WRITE, and DDT (store data) → WAIT with counter = (WRITE ? STORE_LAT : LOAD_LAT) - 1.
- WAIT: if MREQ=0 at an edge → abort to IDLE; no write, no ACK, no err. Else if counter=0 → ACK (register all outputs), else decrement. LAT=1: ACKD_n low in cycle directly after acceptance cycle.
- ACK: ACKD_n=0 for exactly one cycle; next edge → IDLE unconditionally (a following request needs MREQ seen in IDLE; back-to-back = one idle cycle minimum).
- Store commit occurs on the edge entering ACK, using latched data; load data is presented on DDT throughout ACK.
- Endianness: big-endian; byte at addr A is word bits [31:24] when A[1:0]=0.
- Load formatting: word → full 32 bits; half → {16'b0, M[A], M[A+1]}; byte → {24'b0, M[A]}.
- Store sourcing: word DDT[31:0]; half DDT[15:0] (M[A]=DDT[15:8]); byte DDT[7:0]. Other bytes untouched.
- Alignment: half requires A[0]=0, word requires A[1:0]=0. Misaligned → err=1 with ACK, load returns 0, store suppressed.
- Range: A-BASE_ADDR < MEM_BYTES (unsigned, wrap-safe). Out of range and not MMIO → err as above.
- STDOUT_ADDR byte store: stdout_valid=1, stdout_char=DDT[7:0] in ACK cycle; no memory write. Non-byte store to STDOUT → err.
- EXIT_ADDR store, any size: exit_req←1 at ACK, held until reset; no memory write.
- Loads from STDOUT/EXIT return 0, no err.
- DDT is Z in all non-ACK cycles and in store ACK cycles; never driven while WRITE=1.
- Counter width 4 bits. LAT=0 rejected by elaboration-time check.

Decomposition:
- Package dbus_pkg: SIZE encodings (SZ_WORD, SZ_HALF, SZ_BYTE), FSM state enum, default STDOUT/EXIT address constants.
- Sub-module dmem_byte_ram: 4 byte lanes, word-indexed, per-lane write enable, one synchronous write port, combinational read; instantiated once.

Test Plan:
- Reset mid-WAIT (LOAD_LAT=4, rst low at cycle 2) → ACKD_n=1 and DDT=Z immediately; no ACK afterwards.
- LOAD_LAT=3: preload 0x80000000=DE AD BE EF, word load → ACKD_n low exactly 3 cycles after acceptance, DDT=32'hDEADBEEF; half load 0x80000002 → 32'h0000BEEF; byte 0x80000001 → 32'h000000AD.
- STORE_LAT=2: half store DDT=32'h12345678 to 0x80000006, then word load 0x80000004 → bytes 4,5 unchanged, bytes 6,7 = 56 78.
- Byte store 0x48 to 0xf0000000 → stdout_valid pulse, stdout_char=8'h48, memory unchanged; word store to 0xff000000 → exit_req=1 and stays high.
- Misaligned word load 0x80000002 and load from 0x7fff_fffc → err pulse with ACK, DDT=0; misaligned half store → memory unchanged.
- MREQ dropped during WAIT (STORE_LAT=5, drop after 2 cycles) → no ACK, target word unchanged; a new request after that is served normally.
